// File: rtl/ads_touch_pkg.sv
// Shared types and constants for the ADS7843 touch-panel sequencer.
package ads_touch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DEBOUNCE,
        ST_CONV_X,
        ST_CONV_Y,
        ST_SETTLE,
        ST_GAP,
        ST_SETTLE_GAP
    } ads_state_e;

    localparam logic [7:0] CMD_X = 8'hD0;
    localparam logic [7:0] CMD_Y = 8'h90;

    localparam logic [1:0] ADDR_STATUS = 2'd0;
    localparam logic [1:0] ADDR_X      = 2'd1;
    localparam logic [1:0] ADDR_Y      = 2'd2;
    localparam logic [1:0] ADDR_RSVD   = 2'd3;

    localparam int SETTLE_CYC  = 16;
    localparam int XFER_PHASES = 48;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/ads_spi_xfer.sv
// One 24-DCLK ADS7843 conversion: shifts an 8-bit command out, returns the 12-bit result.
module ads_spi_xfer
    import ads_touch_pkg::*;
#(
    parameter int CLK_DIV = 25
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_i,
    input  logic [7:0]  cmd_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [11:0] result_o,
    output logic        cs_n_o,
    output logic        dclk_o,
    output logic        din_o,
    input  logic        dout_i
);

    localparam int               DIV_W    = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic             busy_q, done_q, cs_n_q, dclk_q, din_q;
    logic [DIV_W-1:0] div_q;
    logic [5:0]       ph_q;
    logic [7:0]       cmd_q;
    logic [23:0]      shift_q;
    logic [11:0]      result_q;
    logic             unused_shift;

    always_ff @(posedge clk) begin
        done_q <= 1'b0;
        if (reset) begin
            busy_q <= 1'b0;
            cs_n_q <= 1'b1;
            dclk_q <= 1'b0;
            din_q  <= 1'b0;
            div_q  <= '0;
            ph_q   <= '0;
        end else if (!busy_q) begin
            if (start_i) begin
                busy_q <= 1'b1;
                cs_n_q <= 1'b0;
                din_q  <= cmd_i[7];
                cmd_q  <= {cmd_i[6:0], 1'b0};
                div_q  <= '0;
                ph_q   <= '0;
            end
        end else if (cs_n_q) begin
            // chip-select recovery time before another transaction may start
            if (div_q == DIV_LAST) busy_q <= 1'b0;
            else                   div_q  <= div_q + DIV_W'(1);
        end else if (ph_q == 6'(XFER_PHASES)) begin
            cs_n_q   <= 1'b1;
            done_q   <= 1'b1;
            result_q <= shift_q[14:3];
            div_q    <= '0;
        end else if (div_q == DIV_LAST) begin
            div_q  <= '0;
            ph_q   <= ph_q + 6'd1;
            dclk_q <= ~dclk_q;
            if (!dclk_q) begin
                shift_q <= {shift_q[22:0], dout_i};
            end else begin
                din_q <= cmd_q[7];
                cmd_q <= {cmd_q[6:0], 1'b0};
            end
        end else begin
            div_q <= div_q + DIV_W'(1);
        end
    end

    assign unused_shift = ^{shift_q[23:15], shift_q[2:0]};

    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign result_o = result_q;
    assign cs_n_o   = cs_n_q;
    assign dclk_o   = dclk_q;
    assign din_o    = din_q;

endmodule

// File: rtl/ads_touch_ctrl.sv
// ADS7843 touch sequencer: pen debounce, averaged X/Y bursts, Avalon-MM register slave.
module ads_touch_ctrl
    import ads_touch_pkg::*;
#(
    parameter int CLK_DIV      = 25,
    parameter int DEBOUNCE_CYC = 50000,
    parameter int SAMPLE_GAP   = 500000,
    parameter int AVG_LOG2     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic [15:0] writedata,
    output logic [15:0] readdata,
    output logic        irq,
    input  logic        pen_irq_n,
    output logic        ads_cs_n,
    output logic        ads_dclk,
    output logic        ads_din,
    input  logic        ads_dout
);

    localparam int ACC_W  = 12 + AVG_LOG2;
    localparam int PAIR_W = AVG_LOG2 + 1;
    localparam int NPAIR  = 1 << AVG_LOG2;
    localparam int CNT_W  = $clog2(max3(DEBOUNCE_CYC, SAMPLE_GAP, SETTLE_CYC) + 1);

    ads_state_e        state_q, state_d;
    logic [1:0]        sync_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PAIR_W-1:0] pair_q, pair_d;
    logic [ACC_W-1:0]  acc_x_q, acc_x_d, acc_y_q, acc_y_d;
    logic [11:0]       x_q, x_d, y_q, y_d;
    logic              pend_q, pend_d, pen_db_q, pen_db_d;
    logic              valid_q, irq_en_q, set_valid;
    logic [15:0]       readdata_q;
    logic              pen;
    logic              xfer_start, xfer_busy, xfer_done;
    logic [7:0]        xfer_cmd;
    logic [11:0]       xfer_result;
    logic              unused_wdata;

    assign pen = ~sync_q[1];

    ads_spi_xfer #(.CLK_DIV(CLK_DIV)) u_xfer (
        .clk      (clk),
        .reset    (reset),
        .start_i  (xfer_start),
        .cmd_i    (xfer_cmd),
        .busy_o   (xfer_busy),
        .done_o   (xfer_done),
        .result_o (xfer_result),
        .cs_n_o   (ads_cs_n),
        .dclk_o   (ads_dclk),
        .din_o    (ads_din),
        .dout_i   (ads_dout)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pair_d     = pair_q;
        acc_x_d    = acc_x_q;
        acc_y_d    = acc_y_q;
        x_d        = x_q;
        y_d        = y_q;
        pend_d     = pend_q;
        pen_db_d   = pen_db_q;
        set_valid  = 1'b0;
        xfer_start = 1'b0;
        xfer_cmd   = CMD_X;
        unique case (state_q)
            ST_IDLE: begin
                pen_db_d = 1'b0;
                cnt_d    = CNT_W'(1);
                if (pen) state_d = ST_DEBOUNCE;
            end
            ST_DEBOUNCE: begin
                if (!pen) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_W'(DEBOUNCE_CYC - 1)) begin
                    pen_db_d = 1'b1;
                    acc_x_d  = '0;
                    acc_y_d  = '0;
                    pair_d   = '0;
                    state_d  = ST_CONV_X;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            // pen is deliberately ignored while converting
            ST_CONV_X, ST_CONV_Y: begin
                xfer_cmd   = (state_q == ST_CONV_X) ? CMD_X : CMD_Y;
                xfer_start = !pend_q && !xfer_busy;
                if (xfer_start) pend_d = 1'b1;
                if (xfer_done) begin
                    pend_d = 1'b0;
                    if (state_q == ST_CONV_X) begin
                        acc_x_d = acc_x_q + ACC_W'(xfer_result);
                        state_d = ST_CONV_Y;
                    end else begin
                        acc_y_d = acc_y_q + ACC_W'(xfer_result);
                        pair_d  = pair_q + PAIR_W'(1);
                        cnt_d   = '0;
                        state_d = (pair_d == PAIR_W'(NPAIR)) ? ST_SETTLE : ST_CONV_X;
                    end
                end
            end
            ST_SETTLE, ST_SETTLE_GAP: begin
                if (cnt_q != CNT_W'(SETTLE_CYC - 1)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else if (!pen) begin
                    pen_db_d = 1'b0;
                    state_d  = ST_IDLE;
                end else if (state_q == ST_SETTLE) begin
                    x_d       = acc_x_q[ACC_W-1 -: 12];
                    y_d       = acc_y_q[ACC_W-1 -: 12];
                    set_valid = 1'b1;
                    cnt_d     = '0;
                    state_d   = ST_GAP;
                end else begin
                    acc_x_d = '0;
                    acc_y_d = '0;
                    pair_d  = '0;
                    state_d = ST_CONV_X;
                end
            end
            ST_GAP: begin
                if (cnt_q == CNT_W'(SAMPLE_GAP - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_SETTLE_GAP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q   <= 2'b11;
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            pend_q   <= 1'b0;
            pen_db_q <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
        end else begin
            sync_q   <= {sync_q[0], pen_irq_n};
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
            pen_db_q <= pen_db_d;
            x_q      <= x_d;
            y_q      <= y_d;
        end
        acc_x_q <= acc_x_d;
        acc_y_q <= acc_y_d;
        pair_q  <= pair_d;
    end

    // a fresh result outranks the clear-on-read of Y
    always_ff @(posedge clk) begin
        if (reset) begin
            readdata_q <= '0;
            irq_en_q   <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            if (read) begin
                unique case (address)
                    ADDR_STATUS: readdata_q <= {14'b0, valid_q, pen_db_q};
                    ADDR_X:      readdata_q <= {4'b0, x_q};
                    ADDR_Y:      readdata_q <= {4'b0, y_q};
                    default:     readdata_q <= '0;
                endcase
            end
            if (write && address == ADDR_STATUS) irq_en_q <= writedata[0];
            if (set_valid)                           valid_q <= 1'b1;
            else if (read && address == ADDR_Y)      valid_q <= 1'b0;
        end
    end

    assign unused_wdata = ^writedata[15:1];
    assign readdata     = readdata_q;
    assign irq          = valid_q & irq_en_q;

endmodule

// File: tb/tb_ads_touch_ctrl.sv
// Bench for ads_touch_ctrl: ADS7843 slave model, protocol checks and averaged-result scoreboard.
`timescale 1ns/1ps
module tb_ads_touch_ctrl;

    localparam int CLK_DIV      = 2;
    localparam int DEBOUNCE_CYC = 100;
    localparam int SAMPLE_GAP   = 300;
    localparam int AVG_LOG2     = 2;
    localparam int NPAIR        = 1 << AVG_LOG2;

    logic        clk = 1'b0, reset = 1'b1;
    logic [1:0]  address = 2'd0;
    logic        read = 1'b0, write = 1'b0;
    logic [15:0] writedata = 16'd0;
    logic [15:0] readdata;
    logic        irq;
    logic        pen_irq_n = 1'b1;
    logic        ads_cs_n, ads_dclk, ads_din;
    logic        ads_dout = 1'b0;

    always #5 clk = ~clk;

    ads_touch_ctrl #(
        .CLK_DIV(CLK_DIV), .DEBOUNCE_CYC(DEBOUNCE_CYC),
        .SAMPLE_GAP(SAMPLE_GAP), .AVG_LOG2(AVG_LOG2)
    ) dut (
        .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
        .writedata(writedata), .readdata(readdata), .irq(irq), .pen_irq_n(pen_irq_n),
        .ads_cs_n(ads_cs_n), .ads_dclk(ads_dclk), .ads_din(ads_din), .ads_dout(ads_dout)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ADS7843 slave model and per-cycle protocol checker
    bit          mdl_abort = 1'b1;
    bit          in_tr = 1'b0, next_is_y = 1'b0;
    logic        prev_cs = 1'b1, prev_dclk = 1'b0;
    int          rises = 0, falls = 0, low_len = 0, run = 0;
    int          tr_started = 0, tr_done = 0, dclk_toggles = 0;
    logic [7:0]  exp_cmd;
    logic [11:0] cur_val = 12'd0;
    bit          use_fixed = 1'b0;
    logic [11:0] fixed_x = 12'd0, fixed_y = 12'd0;
    logic [11:0] xq[$], yq[$], served_x[$], served_y[$];

    always @(negedge clk) begin
        int k;
        logic exp_din;
        if (mdl_abort) begin
            in_tr     = 1'b0;
            next_is_y = 1'b0;
        end else begin
            exp_cmd = next_is_y ? 8'h90 : 8'hD0;
            if (ads_dclk != prev_dclk) dclk_toggles++;
            if (ads_cs_n) check("dclk_low_while_deselected", 32'(ads_dclk), 32'd0);
            if (prev_cs && !ads_cs_n) begin
                in_tr = 1'b1; rises = 0; falls = 0; low_len = 0; run = 0;
                tr_started++;
            end
            if (in_tr && !ads_cs_n) begin
                low_len++;
                if (ads_dclk != prev_dclk && low_len > 1) begin
                    check("dclk_half_period", 32'(run), 32'(CLK_DIV));
                    run = 1;
                    if (ads_dclk) begin
                        rises++;
                    end else begin
                        falls++;
                        if (falls == 7) begin
                            if (next_is_y) begin
                                if (use_fixed)        cur_val = fixed_y;
                                else if (yq.size > 0) cur_val = yq.pop_front();
                                else                  cur_val = 12'($urandom);
                                served_y.push_back(cur_val);
                            end else begin
                                if (use_fixed)        cur_val = fixed_x;
                                else if (xq.size > 0) cur_val = xq.pop_front();
                                else                  cur_val = 12'($urandom);
                                served_x.push_back(cur_val);
                            end
                        end
                    end
                end else begin
                    run++;
                end
            end
            if (in_tr && !prev_cs && ads_cs_n) begin
                check("xfer_rising_edges", 32'(rises), 32'd24);
                check("xfer_cs_low_cycles", 32'(low_len), 32'(48 * CLK_DIV + 1));
                tr_done++;
                next_is_y = !next_is_y;
                in_tr = 1'b0;
            end
            exp_din = (in_tr && !ads_cs_n && falls < 8) ? exp_cmd[7 - falls] : 1'b0;
            check("ads_din", 32'(ads_din), 32'(exp_din));
            k = rises + 1;
            ads_dout = (k >= 10 && k <= 21) ? cur_val[21 - k] : 1'($urandom);
        end
        prev_cs   = ads_cs_n;
        prev_dclk = ads_dclk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic [1:0] a, output logic [15:0] d);
        read = 1'b1; address = a;
        tick();
        read = 1'b0;
        d = readdata;
    endtask

    task automatic do_write(input logic [1:0] a, input logic [15:0] d);
        write = 1'b1; address = a; writedata = d;
        tick();
        write = 1'b0;
    endtask

    task automatic wait_irq(input string name, input int bound);
        int n = 0;
        while (irq !== 1'b1 && n < bound) begin
            tick();
            n++;
        end
        check(name, 32'(irq), 32'd1);
    endtask

    function automatic logic [11:0] served_avg(input bit is_y);
        int s = 0;
        if (is_y) foreach (served_y[i]) s += int'(served_y[i]);
        else      foreach (served_x[i]) s += int'(served_x[i]);
        return 12'(s >> AVG_LOG2);
    endfunction

    // Reads X then Y (clearing valid) and compares against the served samples.
    task automatic check_burst(input string tag, output logic [11:0] rx, output logic [11:0] ry);
        logic [15:0] d;
        check({tag, "_x_samples"}, 32'(served_x.size), 32'(NPAIR));
        check({tag, "_y_samples"}, 32'(served_y.size), 32'(NPAIR));
        do_read(2'd0, d); check({tag, "_status"}, 32'(d), 32'h3);
        do_read(2'd1, d); check({tag, "_x"}, 32'(d), 32'(served_avg(1'b0)));
        rx = d[11:0];
        check({tag, "_irq_before_clear"}, 32'(irq), 32'd1);
        do_read(2'd2, d); check({tag, "_y"}, 32'(d), 32'(served_avg(1'b1)));
        ry = d[11:0];
        check({tag, "_irq_after_clear"}, 32'(irq), 32'd0);
        served_x.delete(); served_y.delete();
    endtask

    initial begin
        logic [15:0] d;
        logic [11:0] px, py;
        int base, n;

        repeat (3) tick();
        reset = 1'b0;
        check("rst_readdata", 32'(readdata), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_cs_n", 32'(ads_cs_n), 32'd1);
        check("rst_dclk", 32'(ads_dclk), 32'd0);
        check("rst_din", 32'(ads_din), 32'd0);
        mdl_abort = 1'b0;
        do_read(2'd0, d); check("rst_status", 32'(d), 32'd0);
        do_read(2'd1, d); check("rst_x", 32'(d), 32'd0);
        repeat (1000) tick();
        check("idle_no_xfer", 32'(tr_started), 32'd0);
        check("idle_no_dclk", 32'(dclk_toggles), 32'd0);

        // fixed samples, then two more bursts with random samples while pen stays down
        do_write(2'd0, 16'h0001);
        use_fixed = 1'b1; fixed_x = 12'hA5C; fixed_y = 12'h3F1;
        base = tr_done;
        pen_irq_n = 1'b0;
        wait_irq("fixed_irq", 5000);
        check("fixed_xfer_count", 32'(tr_done - base), 32'(2 * NPAIR));
        use_fixed = 1'b0;
        do_write(2'd1, 16'hFFFF);
        check_burst("fixed", px, py);
        check("fixed_x_literal", 32'(px), 32'h0A5C);
        check("fixed_y_literal", 32'(py), 32'h03F1);
        do_read(2'd0, d); check("status_after_clear", 32'(d), 32'h1);
        do_read(2'd3, d); check("addr3_zero", 32'(d), 32'd0);
        for (int b = 0; b < 2; b++) begin
            base = tr_done;
            wait_irq("rand_irq", 5000);
            check("rand_xfer_count", 32'(tr_done - base), 32'(2 * NPAIR));
            check_burst("rand", px, py);
        end
        pen_irq_n = 1'b1;
        base = tr_started;
        repeat (600) tick();
        do_read(2'd0, d); check("lift_in_gap_status", 32'(d), 32'd0);
        check("lift_in_gap_no_xfer", 32'(tr_started), 32'(base));

        // truncating average
        xq.push_back(12'd100); xq.push_back(12'd101);
        xq.push_back(12'd102); xq.push_back(12'd104);
        pen_irq_n = 1'b0;
        wait_irq("avg_irq", 5000);
        check_burst("avg", px, py);
        check("avg_x_literal", 32'(px), 32'd101);
        pen_irq_n = 1'b1;
        repeat (600) tick();

        // pen lifted during Y of the third pair: burst discarded
        base = tr_started;
        pen_irq_n = 1'b0;
        n = 0;
        while (tr_started < base + 6 && n < 5000) begin tick(); n++; end
        check("third_pair_y_reached", 32'(tr_started - base), 32'd6);
        pen_irq_n = 1'b1;
        n = 0;
        while (tr_done < base + 2 * NPAIR && n < 5000) begin tick(); n++; end
        repeat (100) tick();
        check("discard_xfer_count", 32'(tr_started - base), 32'(2 * NPAIR));
        check("discard_irq", 32'(irq), 32'd0);
        do_read(2'd0, d); check("discard_status", 32'(d), 32'd0);
        do_read(2'd1, d); check("discard_x_kept", 32'(d), 32'(px));
        do_read(2'd2, d); check("discard_y_kept", 32'(d), 32'(py));
        served_x.delete(); served_y.delete();

        // pen glitch one cycle shorter than the debounce window
        base = tr_started;
        pen_irq_n = 1'b0;
        repeat (DEBOUNCE_CYC - 1) tick();
        pen_irq_n = 1'b1;
        repeat (300) tick();
        check("glitch_no_xfer", 32'(tr_started), 32'(base));
        do_read(2'd0, d); check("glitch_status", 32'(d), 32'd0);

        // reset in the middle of a transaction
        pen_irq_n = 1'b0;
        n = 0;
        while (!(in_tr && rises >= 12) && n < 5000) begin tick(); n++; end
        check("reached_dclk_edge12", 32'(rises), 32'd12);
        mdl_abort = 1'b1;
        reset = 1'b1;
        tick();
        check("midreset_cs_n", 32'(ads_cs_n), 32'd1);
        check("midreset_dclk", 32'(ads_dclk), 32'd0);
        reset = 1'b0;
        pen_irq_n = 1'b1;
        repeat (20) tick();
        mdl_abort = 1'b0;
        repeat (300) tick();
        check("midreset_irq", 32'(irq), 32'd0);
        do_read(2'd0, d); check("midreset_status", 32'(d), 32'd0);
        do_read(2'd1, d); check("midreset_x", 32'(d), 32'd0);
        do_read(2'd2, d); check("midreset_y", 32'(d), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ads_touch_ctrl.md
# ads_touch_ctrl

Sequencer for the ADS7843 resistive-touch controller on the 2.4" TFT board. It debounces the pen-interrupt line, then runs 24-clock serial conversions for X and Y, averages 2^AVG_LOG2 sample pairs and discards them if the pen lifted mid-burst. Coordinates are published through a small Avalon-MM slave, replacing software polling of the bare pen-IRQ input port.

## Interface
- CLK_DIV, 25: clk cycles per DCLK half-period (≥2); 25 gives 1 MHz DCLK at 50 MHz.
- DEBOUNCE_CYC, 50000: consecutive cycles pen must read down before a burst starts.
- SAMPLE_GAP, 500000: idle cycles between bursts while the pen stays down.
- AVG_LOG2, 2: log2 of sample pairs per burst (0..4).
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- address  in  2  register select.
- read  in  1  Avalon read strobe.
- write  in  1  Avalon write strobe.
- writedata  in  16  write data.
- readdata  out  16  registered read data.
- irq  out  1  level interrupt: valid & irq_en.
- pen_irq_n  in  1  ADS PENIRQ, asynchronous, active-low.
- ads_cs_n  out  1  chip select.
- ads_dclk  out  1  serial clock.
- ads_din  out  1  command bit to ADS.
- ads_dout  in  1  conversion bit from ADS.

## Operation
- pen_irq_n passes through a 2-flop synchronizer. pen = ~synced value.
- Registers:
  - addr0 read: {14'b0, valid, pen_db}. addr0 write: bit0 irq_en.
  - addr1 read: {4'b0, X}.
  - addr2 read: {4'b0, Y}. This read clears valid.
  - addr3 reads 0.
  - Writes to addr1..3 are ignored.
- Commands, MSB first: X = 8'hD0, Y = 8'h90. Both are 12-bit, differential, power-down between conversions.
- FSM states:
  - IDLE: pen_db=0. Go to DEBOUNCE when pen=1.
  - DEBOUNCE: counter counts while pen=1. If pen=0, return to IDLE. When the count reaches DEBOUNCE_CYC, set pen_db=1, clear the accumulators and pair count, and go to CONV_X.
  - CONV_X, then CONV_Y: one 24-DCLK transaction each. Each result adds into acc_x / acc_y, which are (12+AVG_LOG2) bits wide. After CONV_Y, pair count increments. If pair count < 2^AVG_LOG2, go to CONV_X; otherwise go to SETTLE.
  - SETTLE: cs_n held high for 16 cycles, then pen is sampled.
    - pen=1: X = acc_x >> AVG_LOG2, Y = acc_y >> AVG_LOG2 (truncate). Set valid. Go to GAP.
    - pen=0: discard the burst, clear pen_db, go to IDLE.
  - GAP: count SAMPLE_GAP cycles, then go to SETTLE_GAP.
  - SETTLE_GAP: behaves as SETTLE without the update. pen=1 clears the accumulators and goes to CONV_X. pen=0 clears pen_db and goes to IDLE.
- pen is ignored during CONV_X/CONV_Y because the ADS drives PENIRQ unreliably while converting.
- valid is sticky. A new burst overwrites X/Y whether or not the previous result was read.
- If an addr2 read and a valid set occur in the same cycle, the set wins.

## Timing
- Reset values: readdata=0, irq=0, ads_cs_n=1, ads_dclk=0, ads_din=0, X=Y=0, valid=0, irq_en=0, pen_db=0. FSM in IDLE.
- readdata is registered: data appears the cycle after the read strobe (one cycle of read latency). A valid clear caused by an addr2 read takes effect on that same edge.
- Transaction sequence:
  - ads_cs_n falls and ads_din = cmd[7] in the same cycle.
  - DCLK stays low for CLK_DIV cycles, then alternates high/low every CLK_DIV cycles for 24 rising edges.
  - ads_din updates to the next command bit on each falling edge (edges 1..7). It is 0 after the 8th falling edge.
  - ads_dout shifts into a 24-bit register, left-shifting, in the clk cycle of each rising edge. Result = shift[14:3], i.e. rising edges 10..21 carry D11..D0.
  - After the 24th falling edge, ads_cs_n rises on the next cycle and stays high ≥ CLK_DIV cycles before the next transaction.
- One transaction takes 49·CLK_DIV + 1 cycles.
- Synchronous reset mid-transaction immediately forces cs_n=1 and dclk=0. The partial burst is discarded.

## Structure
- Shared package ads_touch_pkg holds:
  - the FSM state enum
  - command constants CMD_X/CMD_Y
  - register address constants
  - the SETTLE length of 16
- One sub-module, ads_spi_xfer: start/done handshake, 8-bit command in, 12-bit result out, owns DCLK/CS/DIN timing. The start pulse is accepted only when not busy. done is a 1-cycle pulse with the result valid.
- The top level holds the FSM, accumulators, registers and the synchronizer.

## Test plan
- Reset release with pen up and CLK_DIV=2: all outputs at their reset values. readdata of addr0 = 0. No DCLK activity for 1000 cycles.
- ADS model returns X=12'hA5C and Y=12'h3F1 for all samples. AVG_LOG2=2, pen held down. Expected: 8 transactions with commands D0,90 alternating, then addr1=0x0A5C, addr2=0x03F1, valid=1. The addr2 read clears valid.
- Averaging with X samples 100, 101, 102, 104: X = 101 (407>>2, truncated).
- Pen released during CONV_Y of the third pair: burst discarded, X/Y unchanged, valid stays 0, FSM in IDLE, pen_db=0.
- Pen glitch shorter than DEBOUNCE_CYC (DEBOUNCE_CYC=100, pen low 99 cycles): no transaction starts.
- With irq_en=1: irq rises the cycle valid sets and falls the cycle after the addr2 read. A reset asserted at DCLK edge 12 gives cs_n=1 on the next cycle and no update.
